// File: rtl/fifo_wr_packer.sv
// rtl/fifo_wr_packer.sv - packs IN_W-bit beats into RATIO-lane words for a downstream sync FIFO
// Little-endian lane packing with a single output holding register in front of the FIFO.
module fifo_wr_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_last,
  output logic                  fifo_wren,
  output logic [IN_W*RATIO-1:0] fifo_din,
  output logic [RATIO-1:0]      fifo_keep,
  output logic                  fifo_last,
  input  logic                  fifo_full,
  output logic                  busy
);

  localparam int CNT_W = $clog2(RATIO);
  localparam int OUT_W = IN_W * RATIO;

  logic [CNT_W-1:0] r_lane_cnt;
  logic [OUT_W-1:0] r_asm;
  logic [OUT_W-1:0] r_hold_data;
  logic [RATIO-1:0] r_hold_keep;
  logic             r_hold_last;
  logic             r_out_vld;

  logic             w_ready;
  logic             w_wren;
  logic             w_accept;
  logic             w_complete;
  logic             w_last_lane;
  logic [OUT_W-1:0] w_word;
  logic [RATIO-1:0] w_keep;

  assign w_ready     = ~(r_out_vld & fifo_full);
  assign w_wren      = r_out_vld & ~fifo_full;
  assign w_accept    = in_valid & w_ready;
  assign w_last_lane = (r_lane_cnt == CNT_W'(RATIO - 1));
  assign w_complete  = w_accept & (w_last_lane | in_last);

  // Word as it would stand with the current beat inserted; lanes above it are forced to zero.
  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) < r_lane_cnt) begin
        w_word[i*IN_W +: IN_W] = r_asm[i*IN_W +: IN_W];
        w_keep[i]              = 1'b1;
      end else if (CNT_W'(i) == r_lane_cnt) begin
        w_word[i*IN_W +: IN_W] = in_data;
        w_keep[i]              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane_cnt  <= '0;
      r_asm       <= '0;
      r_hold_data <= '0;
      r_hold_keep <= '0;
      r_hold_last <= 1'b0;
      r_out_vld   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          r_asm       <= '0;
          r_lane_cnt  <= '0;
          r_hold_data <= w_word;
          r_hold_keep <= w_keep;
          r_hold_last <= in_last;
        end else begin
          r_asm      <= w_word;
          r_lane_cnt <= r_lane_cnt + CNT_W'(1);
        end
      end
      // A completion on the draining edge reloads the holder, so out_vld stays set.
      if (w_complete) begin
        r_out_vld <= 1'b1;
      end else if (w_wren) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready;
  assign fifo_wren = w_wren;
  assign fifo_din  = r_hold_data;
  assign fifo_keep = r_hold_keep;
  assign fifo_last = r_hold_last;
  assign busy      = r_out_vld | (r_lane_cnt != '0);

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb/tb_fifo_wr_packer.sv - directed and randomized checks of fifo_wr_packer against a packet-chunking model
module tb_fifo_wr_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             fifo_wren;
  logic [OUT_W-1:0] fifo_din;
  logic [RATIO-1:0] fifo_keep;
  logic             fifo_last;
  logic             fifo_full = 1'b0;
  logic             busy;

  fifo_wr_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .fifo_wren(fifo_wren), .fifo_din(fifo_din), .fifo_keep(fifo_keep), .fifo_last(fifo_last),
    .fifo_full(fifo_full), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  typedef struct packed {
    logic [IN_W-1:0] data;
    logic            last;
  } beat_t;

  word_t           exp_q[$];
  beat_t           beat_q[$];
  logic [IN_W-1:0] pb[$];
  word_t           last_wr;

  int checks = 0, errors = 0;
  int cyc = 0, wr_cnt = 0, acc_cnt = 0, stall_ready = 0, pkt_pos = 0, cmp_cyc = -10;
  bit lat_chk = 0;
  bit seen_ready = 0, seen_wren = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected words come from cutting each packet into RATIO-byte chunks.
  task automatic add_pkt();
    for (int k = 0; k < pb.size(); k += RATIO) begin
      word_t w;
      w = '0;
      for (int j = 0; j < RATIO && k + j < pb.size(); j++) begin
        w.data[j*IN_W +: IN_W] = pb[k+j];
        w.keep[j]              = 1'b1;
      end
      w.last = (k + RATIO >= pb.size());
      exp_q.push_back(w);
    end
    for (int i = 0; i < pb.size(); i++) beat_q.push_back({pb[i], i == pb.size() - 1});
    pb.delete();
  endtask

  task automatic cycle(input int pv, input int pf);
    fifo_full = ($urandom_range(99) < pf);
    if (beat_q.size() > 0 && $urandom_range(99) < pv) begin
      in_valid = 1'b1;
      in_data  = beat_q[0].data;
      in_last  = beat_q[0].last;
    end else begin
      in_valid = 1'b0;
      in_data  = IN_W'($urandom);
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    seen_ready = in_ready;
    seen_wren  = fifo_wren;
    if (!in_ready) stall_ready++;
    if (fifo_wren) begin
      chk("wren_while_full", {31'd0, fifo_full}, 32'd0);
      wr_cnt++;
      last_wr = {fifo_din, fifo_keep, fifo_last};
      if (lat_chk) chk("write_latency", cyc, cmp_cyc + 1);
      if (exp_q.size() == 0) begin
        chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        chk("din", fifo_din, e.data);
        chk("keep", {28'd0, fifo_keep}, {28'd0, e.keep});
        chk("last", {31'd0, fifo_last}, {31'd0, e.last});
      end
    end
    if (in_valid && in_ready) begin
      acc_cnt++;
      pkt_pos++;
      if (in_last || pkt_pos == RATIO) begin
        cmp_cyc = cyc;
        pkt_pos = 0;
      end
      void'(beat_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_wren"}, {31'd0, fifo_wren}, 32'd0);
    chk({tag, "_din"}, fifo_din, 32'd0);
    chk({tag, "_keep"}, {28'd0, fifo_keep}, 32'd0);
    chk({tag, "_last"}, {31'd0, fifo_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    in_valid  = 1'b0;
    fifo_full = 1'b0;
    #1;
    check_idle("rst_during");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_idle("rst_after");
    beat_q.delete();
    exp_q.delete();
    pkt_pos = 0;
  endtask

  initial begin
    int n, n_words, total;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Full word, back to back
    lat_chk = 1;
    wr_cnt  = 0;
    pb = '{8'h11, 8'h22, 8'h33, 8'h44};
    add_pkt();
    repeat (6) cycle(100, 0);
    chk("basic_writes", wr_cnt, 1);
    chk("basic_din", last_wr.data, 32'h44332211);
    chk("basic_keep", {28'd0, last_wr.keep}, 32'hf);
    chk("basic_last", {31'd0, last_wr.last}, 32'd1);
    chk("basic_busy", {31'd0, busy}, 32'd0);

    // Short packet, then the next packet must start in lane 0
    pb = '{8'hA1, 8'hA2};
    add_pkt();
    repeat (4) cycle(100, 0);
    chk("short_din", last_wr.data, 32'h0000A2A1);
    chk("short_keep", {28'd0, last_wr.keep}, 32'h3);
    pb = '{8'hB1, 8'hB2, 8'hB3};
    add_pkt();
    repeat (5) cycle(100, 0);
    chk("lane0_din", last_wr.data, 32'h00B3B2B1);
    chk("lane0_keep", {28'd0, last_wr.keep}, 32'h7);

    // Back-pressure: holder stalls, input blocked, then drains in order
    lat_chk = 0;
    wr_cnt  = 0;
    acc_cnt = 0;
    pb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    add_pkt();
    repeat (5) cycle(100, 100);
    repeat (7) begin
      cycle(100, 100);
      chk("hold_stable", fifo_din, 32'h04030201);
    end
    chk("stall_accepts", acc_cnt, 4);
    chk("stall_writes", wr_cnt, 0);
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    cycle(100, 0);
    chk("fall_wren", {31'd0, seen_wren}, 32'd1);
    chk("fall_ready", {31'd0, seen_ready}, 32'd1);
    repeat (8) cycle(100, 0);
    chk("drain_writes", wr_cnt, 2);
    chk("drain_din", last_wr.data, 32'h08070605);
    chk("drain_exp_empty", exp_q.size(), 0);

    // Sustained stream: one beat per cycle, one write every RATIO cycles
    lat_chk     = 1;
    wr_cnt      = 0;
    stall_ready = 0;
    for (int i = 0; i < 64; i++) pb.push_back(IN_W'($urandom));
    add_pkt();
    repeat (66) cycle(100, 0);
    chk("stream_ready_drops", stall_ready, 0);
    chk("stream_writes", wr_cnt, 16);
    chk("stream_busy", {31'd0, busy}, 32'd0);
    chk("stream_exp_empty", exp_q.size(), 0);

    // Reset with a partial word, then with a pending word
    for (int i = 0; i < 6; i++) pb.push_back(IN_W'(8'hC0 + i));
    add_pkt();
    repeat (2) cycle(100, 0);
    chk("partial_busy", {31'd0, busy}, 32'd1);
    do_reset();
    pb = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    add_pkt();
    repeat (5) cycle(100, 100);
    chk("pending_busy", {31'd0, busy}, 32'd1);
    do_reset();
    wr_cnt = 0;
    pb = '{8'h55, 8'h66};
    add_pkt();
    repeat (4) cycle(100, 0);
    chk("post_rst_writes", wr_cnt, 1);
    chk("post_rst_din", last_wr.data, 32'h00006655);
    chk("post_rst_keep", {28'd0, last_wr.keep}, 32'h3);

    // Random traffic and back-pressure
    lat_chk = 0;
    wr_cnt  = 0;
    total   = 0;
    while (total < 10000) begin
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) pb.push_back(IN_W'($urandom));
      add_pkt();
      total += n;
    end
    n_words = exp_q.size();
    n = 0;
    while ((beat_q.size() != 0 || exp_q.size() != 0) && n < 60000) begin
      cycle(70, 30);
      n++;
    end
    chk("rand_beats_left", beat_q.size(), 0);
    chk("rand_words_left", exp_q.size(), 0);
    chk("rand_writes", wr_cnt, n_words);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
